// File: rtl/axi_pkg.sv
// Shared types and constants for the AXI slave write responder.
// Consumed by axi_slave_write_responder and axi_burst_addr_gen.
package axi_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10,
        RSVD  = 2'b11
    } burst_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DATA = 2'b01,
        RESP = 2'b10
    } wr_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // WRAP bursts are legal only for 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
// Arithmetic is ADDR_W bits wide and wraps modulo 2^ADDR_W.
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [2:0]        size_i,
    input  logic [7:0]        len_i,
    input  burst_e            burst_i,
    output logic [ADDR_W-1:0] next_addr_c
);

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] wrap_mask;

    always_comb begin
        step        = ADDR_W'(1) << size_i;
        // Wrap boundary is (len+1)*step bytes; mask selects the offset inside it.
        wrap_mask   = ((ADDR_W'(len_i) + ADDR_W'(1)) << size_i) - ADDR_W'(1);
        next_addr_c = addr_i;
        case (burst_i)
            FIXED:   next_addr_c = addr_i;
            INCR:    next_addr_c = (addr_i & ~(step - ADDR_W'(1))) + step;
            WRAP:    next_addr_c = (addr_i & ~wrap_mask) | ((addr_i + step) & wrap_mask);
            default: next_addr_c = addr_i;
        endcase
    end

endmodule

// File: rtl/axi_slave_write_responder.sv
// AXI slave write responder: one AW burst at a time, W beats to a byte-strobed memory port, one B.
// Optional AXI_SLV_WLAST_CHECK_EN: flag SLVERR when wlast disagrees with the beat count.
module axi_slave_write_responder
    import axi_pkg::*;
#(
    parameter int unsigned ID_W   = 12,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
) (
    input  logic                clk,
    input  logic                s_axi_aresetn,
    input  logic [ID_W-1:0]     s_axi_awid,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic [7:0]          s_axi_awlen,
    input  logic [2:0]          s_axi_awsize,
    input  logic [1:0]          s_axi_awburst,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [ID_W-1:0]     s_axi_bid,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb
);

    localparam int unsigned STRB_W   = DATA_W / 8;
    localparam int unsigned SIZE_MAX = $clog2(STRB_W);

    wr_state_e           state_q, state_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          len_q, len_d;
    logic [2:0]          size_q, size_d;
    burst_e              burst_q, burst_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                err_q, err_d;

    logic                awready_q, awready_d;
    logic                wready_q, wready_d;
    logic                bvalid_q, bvalid_d;
    logic [ID_W-1:0]     bid_q, bid_d;
    logic [1:0]          bresp_q, bresp_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;

    logic [ADDR_W-1:0]   next_addr_c;
    logic                aw_err_c;
    logic                last_beat_c;
    logic                beat_err_c;
    burst_e              aw_burst_c;

    axi_burst_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .addr_i      (addr_q),
        .size_i      (size_q),
        .len_i       (len_q),
        .burst_i     (burst_q),
        .next_addr_c (next_addr_c)
    );

    // Illegal burst shapes are accepted but answered with SLVERR and no byte writes.
    always_comb begin
        aw_burst_c = burst_e'(s_axi_awburst);
        aw_err_c   = (s_axi_awsize > 3'(SIZE_MAX))
                  || (aw_burst_c == RSVD)
                  || ((aw_burst_c == WRAP) && !wrap_len_ok(s_axi_awlen));
        last_beat_c = (cnt_q == len_q);
    end

`ifdef AXI_SLV_WLAST_CHECK_EN
    assign beat_err_c = (s_axi_wlast != last_beat_c);
`else
    logic unused_wlast;
    assign unused_wlast = s_axi_wlast;
    assign beat_err_c   = 1'b0;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        size_d      = size_q;
        burst_d     = burst_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        bid_d       = bid_q;
        bresp_d     = bresp_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;

        case (state_q)
            IDLE: begin
                if (s_axi_awvalid) begin
                    id_d    = s_axi_awid;
                    addr_d  = s_axi_awaddr;
                    len_d   = s_axi_awlen;
                    size_d  = s_axi_awsize;
                    burst_d = aw_burst_c;
                    cnt_d   = 8'd0;
                    err_d   = aw_err_c;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (s_axi_wvalid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = s_axi_wdata;
                    mem_wstrb_d = (err_q || beat_err_c) ? '0 : s_axi_wstrb;
                    err_d       = err_q || beat_err_c;
                    cnt_d       = cnt_q + 8'd1;
                    addr_d      = next_addr_c;
                    if (last_beat_c) begin
                        bid_d   = id_q;
                        bresp_d = (err_q || beat_err_c) ? RESP_SLVERR : RESP_OKAY;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (s_axi_bready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        awready_d = (state_d == IDLE);
        wready_d  = (state_d == DATA);
        bvalid_d  = (state_d == RESP);
    end

    always_ff @(posedge clk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q     <= IDLE;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= FIXED;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            awready_q   <= 1'b1;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bid_q       <= '0;
            bresp_q     <= RESP_OKAY;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            bid_q       <= bid_d;
            bresp_q     <= bresp_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bid     = bid_q;
    assign s_axi_bresp   = bresp_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_wstrb     = mem_wstrb_q;

endmodule
